// File: rtl/sram_port_arbiter_if.sv
// Request/response port bundle shared by the instruction and data fakecaches.
// master = requester side (fakecache), slave = arbiter side.
interface sram_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req;
   logic [DATA_W/8-1:0]   we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between the instruction-side and
// data-side request ports. Data side wins by default; a saturating starvation
// counter hands priority to the instruction side after STARVE_LIMIT denied
// cycles. The one-cycle read latency is tracked so each response returns to
// the port that was granted.
module sram_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sram_port_arbiter_if.slave    inst,
   sram_port_arbiter_if.slave    data,
   output logic                  sram_en,
   output logic [DATA_W/8-1:0]   sram_we,
   output logic [ADDR_W-1:0]     sram_addr,
   output logic [DATA_W-1:0]     sram_wdata,
   input  logic [DATA_W-1:0]     sram_rdata
);

   localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             inst_starve;
   logic             inst_gnt;
   logic             data_gnt;
   logic             resp_vld;
   logic             resp_own;

   // Grant decision; rst_n gating keeps every grant low while in reset.
   always_comb begin
      inst_starve = inst.req && (starve_cnt == LIMIT);
      data_gnt    = rst_n && data.req && !inst_starve;
      inst_gnt    = rst_n && inst.req && !data_gnt;
   end

   // Drive the SRAM from whichever side holds the grant; idle bus is all zero.
   always_comb begin
      sram_en    = inst_gnt | data_gnt;
      sram_we    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (data_gnt) begin
         sram_we    = data.we;
         sram_addr  = data.addr;
         sram_wdata = data.wdata;
      end else if (inst_gnt) begin
         sram_we    = inst.we;
         sram_addr  = inst.addr;
         sram_wdata = inst.wdata;
      end
   end

   // Starvation counter: clears when inst is idle or served, saturates at LIMIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!inst.req || inst_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Response tracking: one access in flight, owner recorded at grant time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_vld <= 1'b0;
         resp_own <= 1'b0;
      end else begin
         resp_vld <= sram_en;
         resp_own <= data_gnt;
      end
   end

   assign inst.gnt    = inst_gnt;
   assign data.gnt    = data_gnt;
   assign inst.rvalid = resp_vld && !resp_own;
   assign data.rvalid = resp_vld && resp_own;
   assign inst.rdata  = sram_rdata;
   assign data.rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, scoreboard of expected
// responses pushed at grant time and popped when rvalid is due.
module tb_sram_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic [31:0] sram_tmp;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   typedef struct {
      bit          own;    // 1 = data side
      bit          rd;
      logic [31:0] rdata;
   } resp_t;

   resp_t       sb[$];
   logic [31:0] mem [logic [31:0]];

   sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
   sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();

   sram_port_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .STARVE_LIMIT(4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inst      (inst_if),
      .data      (data_if),
      .sram_en   (sram_en),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return ~a;
   endfunction

   // Behavioural single-port SRAM with one-cycle read latency.
   always @(posedge clk) begin
      if (sram_en) begin
         sram_tmp = rd_mem(sram_addr);
         sram_rdata <= sram_tmp;
         if (|sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_we[b]) sram_tmp[8*b +: 8] = sram_wdata[8*b +: 8];
            mem[sram_addr] = sram_tmp;
         end
      end
   end

   task automatic test_reset();
      inst_if.req = 1'b1;
      data_if.req = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({inst_if.gnt, data_if.gnt} !== 2'b00)
         $display("FAIL reset_gnt: got %b expected 00", {inst_if.gnt, data_if.gnt});
      checks++;
      if (sram_en !== 1'b0 || sram_we !== 4'h0)
         $display("FAIL reset_sram: got en=%b we=%h expected en=0 we=0", sram_en, sram_we);
      checks++;
      if ({inst_if.rvalid, data_if.rvalid} !== 2'b00)
         $display("FAIL reset_rvalid: got %b expected 00", {inst_if.rvalid, data_if.rvalid});
      checks++;
      if (dut.starve_cnt !== '0)
         $display("FAIL reset_starve_cnt: got %0d expected 0", dut.starve_cnt);
      failures += ({inst_if.gnt, data_if.gnt} !== 2'b00) + (sram_en !== 1'b0 || sram_we !== 4'h0)
                + ({inst_if.rvalid, data_if.rvalid} !== 2'b00) + (dut.starve_cnt !== '0);
      @(posedge clk); #1;
      inst_if.req = 1'b0;
      data_if.req = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_lone_inst_read();
      resp_t e;
      mem[32'h1c00_0000] = 32'h1234_5678;
      inst_if.req  = 1'b1;
      inst_if.we   = 4'h0;
      inst_if.addr = 32'h1c00_0000;
      @(negedge clk);
      checks++;
      if ({inst_if.gnt, data_if.gnt, sram_en} !== 3'b101) begin
         failures++;
         $display("FAIL lone_inst_gnt: got ig/dg/en=%b expected 101", {inst_if.gnt, data_if.gnt, sram_en});
      end
      checks++;
      if (sram_addr !== 32'h1c00_0000 || sram_we !== 4'h0) begin
         failures++;
         $display("FAIL lone_inst_bus: got addr=%h we=%h expected addr=1c000000 we=0", sram_addr, sram_we);
      end
      sb.push_back('{own: 1'b0, rd: 1'b1, rdata: rd_mem(32'h1c00_0000)});
      @(posedge clk); #1;
      inst_if.req = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({inst_if.rvalid, data_if.rvalid} !== 2'b10) begin
         failures++;
         $display("FAIL lone_inst_rvalid: got i/d=%b expected 10", {inst_if.rvalid, data_if.rvalid});
      end
      checks++;
      if (inst_if.rdata !== e.rdata) begin
         failures++;
         $display("FAIL lone_inst_rdata: got %h expected %h", inst_if.rdata, e.rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_contention();
      bit          exp_d[12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
      int unsigned di = 0;
      int unsigned ii = 0;
      resp_t       e;
      logic [31:0] got;
      inst_if.we = 4'h0;
      data_if.we = 4'h0;
      for (int k = 0; k < 13; k++) begin
         inst_if.addr = 32'h1c00_0100 + 32'(ii * 4);
         data_if.addr = 32'h0000_1000 + 32'(di * 4);
         inst_if.req  = (k < 12);
         data_if.req  = (k < 12);
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({data_if.rvalid, inst_if.rvalid} !== (e.own ? 2'b10 : 2'b01)) begin
               failures++;
               $display("FAIL contention_rvalid[%0d]: got d/i=%b expected own=%0d", k,
                        {data_if.rvalid, inst_if.rvalid}, e.own);
            end
            got = e.own ? data_if.rdata : inst_if.rdata;
            checks++;
            if (got !== e.rdata) begin
               failures++;
               $display("FAIL contention_rdata[%0d]: got %h expected %h", k, got, e.rdata);
            end
         end
         if (k < 12) begin
            checks++;
            if ({data_if.gnt, inst_if.gnt} !== (exp_d[k] ? 2'b10 : 2'b01)) begin
               failures++;
               $display("FAIL contention_gnt[%0d]: got d/i=%b expected data=%0d", k,
                        {data_if.gnt, inst_if.gnt}, exp_d[k]);
            end
            sb.push_back('{own: exp_d[k], rd: 1'b1,
                           rdata: rd_mem(exp_d[k] ? data_if.addr : inst_if.addr)});
            if (exp_d[k]) di++; else ii++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_data_write();
      resp_t e;
      logic [31:0] old;
      old = rd_mem(32'h0000_0800);
      data_if.req   = 1'b1;
      data_if.we    = 4'b0011;
      data_if.addr  = 32'h0000_0800;
      data_if.wdata = 32'hdead_beef;
      @(negedge clk);
      checks++;
      if ({data_if.gnt, sram_en, sram_we} !== {2'b11, 4'b0011}) begin
         failures++;
         $display("FAIL write_gnt_we: got gnt=%b en=%b we=%b expected 1 1 0011", data_if.gnt, sram_en, sram_we);
      end
      checks++;
      if (sram_wdata !== 32'hdead_beef || sram_addr !== 32'h0000_0800) begin
         failures++;
         $display("FAIL write_bus: got addr=%h wdata=%h expected 00000800 deadbeef", sram_addr, sram_wdata);
      end
      sb.push_back('{own: 1'b1, rd: 1'b0, rdata: 32'h0});
      @(posedge clk); #1;
      data_if.we = 4'h0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({data_if.rvalid, inst_if.rvalid} !== 2'b10) begin
         failures++;
         $display("FAIL write_ack: got d/i=%b expected 10", {data_if.rvalid, inst_if.rvalid});
      end
      // Same-address read issued back-to-back with the write ack.
      sb.push_back('{own: 1'b1, rd: 1'b1, rdata: {old[31:16], 16'hbeef}});
      @(posedge clk); #1;
      data_if.req = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (data_if.rvalid !== 1'b1 || data_if.rdata !== e.rdata) begin
         failures++;
         $display("FAIL write_readback: got rvalid=%b rdata=%h expected 1 %h", data_if.rvalid, data_if.rdata, e.rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_starve_drop();
      bit          inst_on[9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
      bit          exp_d[9]   = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
      int unsigned di = 0;
      resp_t       e;
      logic [31:0] got;
      inst_if.we   = 4'h0;
      data_if.we   = 4'h0;
      inst_if.addr = 32'h1c00_0200;
      for (int k = 0; k < 10; k++) begin
         data_if.addr = 32'h0000_3000 + 32'(di * 4);
         inst_if.req  = (k < 9) ? inst_on[k] : 1'b0;
         data_if.req  = (k < 9);
         @(negedge clk);
         if (k == 4) begin
            checks++;
            if (dut.starve_cnt !== '0) begin
               failures++;
               $display("FAIL starve_cnt_cleared: got %0d expected 0", dut.starve_cnt);
            end
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            got = e.own ? data_if.rdata : inst_if.rdata;
            checks++;
            if ({data_if.rvalid, inst_if.rvalid} !== (e.own ? 2'b10 : 2'b01) || got !== e.rdata) begin
               failures++;
               $display("FAIL starve_resp[%0d]: got d/i=%b rdata=%h expected own=%0d rdata=%h", k,
                        {data_if.rvalid, inst_if.rvalid}, got, e.own, e.rdata);
            end
         end
         if (k < 9) begin
            checks++;
            if ({data_if.gnt, inst_if.gnt} !== (exp_d[k] ? 2'b10 : 2'b01)) begin
               failures++;
               $display("FAIL starve_gnt[%0d]: got d/i=%b expected data=%0d", k,
                        {data_if.gnt, inst_if.gnt}, exp_d[k]);
            end
            sb.push_back('{own: exp_d[k], rd: 1'b1,
                           rdata: rd_mem(exp_d[k] ? data_if.addr : inst_if.addr)});
            if (exp_d[k]) di++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      resp_t e;
      data_if.req  = 1'b1;
      data_if.we   = 4'h0;
      data_if.addr = 32'h0000_2000;
      @(negedge clk);
      checks++;
      if (data_if.gnt !== 1'b1) begin
         failures++;
         $display("FAIL midreset_gnt: got %b expected 1", data_if.gnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      data_if.req = 1'b0;
      @(negedge clk);
      checks++;
      if ({data_if.rvalid, inst_if.rvalid, sram_en} !== 3'b000) begin
         failures++;
         $display("FAIL midreset_rvalid: got d/i/en=%b expected 000", {data_if.rvalid, inst_if.rvalid, sram_en});
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      data_if.req  = 1'b1;
      data_if.addr = 32'h0000_2004;
      @(negedge clk);
      checks++;
      if (data_if.gnt !== 1'b1) begin
         failures++;
         $display("FAIL postreset_gnt: got %b expected 1", data_if.gnt);
      end
      sb.push_back('{own: 1'b1, rd: 1'b1, rdata: rd_mem(32'h0000_2004)});
      @(posedge clk); #1;
      data_if.req = 1'b0;
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (data_if.rvalid !== 1'b1 || inst_if.rvalid !== 1'b0 || data_if.rdata !== e.rdata) begin
         failures++;
         $display("FAIL postreset_read: got rvalid=%b rdata=%h expected 1 %h", data_if.rvalid, data_if.rdata, e.rdata);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n         = 1'b0;
      sram_rdata    = '0;
      inst_if.req   = 1'b0;
      inst_if.we    = '0;
      inst_if.addr  = '0;
      inst_if.wdata = '0;
      data_if.req   = 1'b0;
      data_if.we    = '0;
      data_if.addr  = '0;
      data_if.wdata = '0;

      test_reset();
      test_lone_inst_read();
      test_contention();
      test_data_write();
      test_starve_drop();
      test_reset_mid();

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
